ccg_vector_sequencer: RTL and testbench

- Sequences one combinational CCG benchmark netlist: drives its 21-bit input vector (x0..x20), waits a fixed settle time, then captures its 19-bit response (f1..f19).
- Vectors come from an internal LFSR or an external ready/valid stream.
- Responses are compacted into a 19-bit MISR signature and compared against an expected value.
- Sits between the test/dataset harness and the unclocked CCG netlist so each netlist can be exercised in a clocked environment.

---
 rtl/ccg_vector_sequencer_pkg.sv | 7 +
 rtl/ccg_vector_sequencer_misr.sv | 19 +
 rtl/ccg_vector_sequencer.sv | 95 +++++++++
 tb/tb_ccg_vector_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ccg_vector_sequencer_pkg.sv
// ccg_seq_pkg: shared FSM states and LFSR/MISR constants for the CCG vector sequencer.
package ccg_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DONE} state_e;
  localparam logic [20:0] LFSR_TAPS = 21'h140000;
  localparam logic [18:0] MISR_POLY = 19'h40023;
  localparam logic [18:0] MISR_INIT = 19'h7FFFF;
endpackage

// File: rtl/ccg_vector_sequencer_misr.sv
// ccg_misr: response compactor, x^19+x^6+x^2+x+1 MISR with sync init and enable.
module ccg_misr
  import ccg_seq_pkg::*;
#(
  parameter int FW = 19,
  parameter logic [FW-1:0] POLY = FW'(MISR_POLY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          en,
  input  logic [FW-1:0] d,
  output logic [FW-1:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= FW'(MISR_INIT);
    else if (init) sig <= FW'(MISR_INIT);
    else if (en) sig <= {sig[FW-2:0], ^(sig & POLY)} ^ d;
endmodule

// File: rtl/ccg_vector_sequencer.sv
// ccg_vector_sequencer: drives a CCG netlist with LFSR/stream vectors and compacts responses.
// Define CCG_RESP_LOG_EN to add the resp_valid/resp_data raw response log outputs.
module ccg_vector_sequencer
  import ccg_seq_pkg::*;
#(
  parameter int XW         = 21,
  parameter int FW         = 19,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ext_mode,
  input  logic [CNT_W-1:0] vec_count,
  input  logic [XW-1:0]    seed,
  input  logic [FW-1:0]    exp_sig,
  input  logic             ext_valid,
  input  logic [XW-1:0]    ext_vec,
  output logic             ext_ready,
  output logic [XW-1:0]    dut_x,
  input  logic [FW-1:0]    dut_f,
  output logic             busy,
  output logic             done,
  output logic [FW-1:0]    signature,
`ifdef CCG_RESP_LOG_EN
  output logic             resp_valid,
  output logic [FW-1:0]    resp_data,
`endif
  output logic             pass
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  state_e state_q, state_d, after_load;
  logic mode_q, load_fire, kick;
  logic [CNT_W-1:0] cnt_q;
  logic [XW-1:0] lfsr_q;
  logic [FW-1:0] exp_q;
  logic [3:0] settle_q;
  assign kick       = state_q == IDLE && start;
  assign load_fire  = !mode_q || ext_valid;
  assign after_load = SETTLE_CYC == 0 ? CAPTURE : SETTLE;
  assign ext_ready  = state_q == LOAD && mode_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  always_comb begin
    state_d = state_q == IDLE    ? (start ? (vec_count == '0 ? DONE : LOAD) : IDLE)
            : state_q == LOAD    ? (load_fire ? after_load : LOAD)
            : state_q == SETTLE  ? (settle_q == SETTLE_LAST ? CAPTURE : SETTLE)
            : state_q == CAPTURE ? (cnt_q == CNT_W'(1) ? DONE : LOAD)
            : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      dut_x    <= '0;
      pass     <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      lfsr_q   <= XW'(1);
      exp_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= state_q == SETTLE ? settle_q + 4'd1 : 4'd0;
      if (kick) begin
        mode_q <= ext_mode;
        cnt_q  <= vec_count;
        lfsr_q <= seed == '0 ? XW'(1) : seed;
        exp_q  <= exp_sig;
        pass   <= 1'b0;
      end
      if (state_q == LOAD && load_fire) dut_x <= mode_q ? ext_vec : lfsr_q;
      if (state_q == LOAD && !mode_q) lfsr_q <= {lfsr_q[XW-2:0], ^(lfsr_q & XW'(LFSR_TAPS))};
      if (state_q == CAPTURE) cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == DONE) pass <= signature == exp_q;
    end
`ifdef CCG_RESP_LOG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= state_q == CAPTURE;
      if (state_q == CAPTURE) resp_data <= dut_f;
    end
`endif
  ccg_misr #(.FW(FW)) u_misr (
    .clk (clk),
    .rst (rst),
    .init(kick),
    .en  (state_q == CAPTURE),
    .d   (dut_f),
    .sig (signature)
  );
endmodule

// File: tb/tb_ccg_vector_sequencer.sv
// tb_ccg_vector_sequencer: directed scoreboard bench for the CCG vector sequencer.
module tb_ccg_vector_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ext_mode = 1'b0, ext_valid = 1'b0;
  logic [15:0] vec_count = '0;
  logic [20:0] seed = '0, ext_vec = '0, dut_x, prev_x = '0;
  logic [18:0] exp_sig = '0, dut_f, signature, sig, sig_clean;
  logic ext_ready, busy, done, pass;
  int n_chk = 0, n_fail = 0, bc;
  logic [20:0] vq[$];
  logic [18:0] sq[$];
  logic [20:0] ev[3];
  time start_t = 0, done_t = 0;

  always #5 clk = ~clk;
  assign dut_f = dut_x[18:0];

  ccg_vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .ext_mode(ext_mode), .vec_count(vec_count),
    .seed(seed), .exp_sig(exp_sig), .ext_valid(ext_valid), .ext_vec(ext_vec),
    .ext_ready(ext_ready), .dut_x(dut_x), .dut_f(dut_f), .busy(busy), .done(done),
    .signature(signature), .pass(pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [20:0] lnext(input logic [20:0] l);
    return {l[19:0], l[20] ^ l[18]};
  endfunction

  function automatic logic [18:0] mstep(input logic [18:0] m, input logic [18:0] f);
    return {m[17:0], m[18] ^ m[5] ^ m[1] ^ m[0]} ^ f;
  endfunction

  function automatic int done_cyc();
    return int'((done_t - start_t + 5) / 10);
  endfunction

  // Monitor: pop an expected vector on every new dut_x, an expected signature on done.
  always @(negedge clk) begin
    if (busy && dut_x !== prev_x) begin
      if (vq.size() == 0) chk("vec_unexpected", dut_x, prev_x);
      else chk("vec", dut_x, vq.pop_front());
    end
    prev_x = dut_x;
    if (done) begin
      done_t = $time;
      if (sq.size() == 0) chk("done_unexpected", done, 0);
      else chk("sig_at_done", signature, sq.pop_front());
    end
  end

  task automatic run_start(input bit ext, input int cnt, input logic [20:0] sd,
                           input logic [18:0] flip, output logic [18:0] s);
    logic [20:0] l, v;
    l = (sd == '0) ? 21'd1 : sd;
    s = 19'h7FFFF;
    for (int i = 0; i < cnt; i++) begin
      v = ext ? ev[i] : l;
      vq.push_back(v);
      s = mstep(s, v[18:0]);
      l = lnext(l);
    end
    sq.push_back(s);
    @(negedge clk);
    ext_mode = ext; vec_count = 16'(cnt); seed = sd; exp_sig = s ^ flip; start = 1'b1;
    @(posedge clk);
    start_t = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 2000) begin chk("idle_timeout", busy, 0); break; end
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    forever begin
      @(negedge clk);
      if (ext_ready) break;
      g++;
      if (g > 100) begin chk("ready_timeout", ext_ready, 1); break; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dut_x", dut_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ready", ext_ready, 0);
    chk("rst_sig", signature, 19'h7FFFF);
    rst = 1'b0;

    run_start(0, 4, 21'h1, '0, sig);
    wait_idle(bc);
    chk("t1_busy_cycles", bc, 17);
    chk("t1_done_cycle", done_cyc(), 17);
    chk("t1_sig", signature, sig);
    chk("t1_pass", pass, 1);
    chk("t1_dutx_hold", dut_x, 21'h8);

    run_start(0, 0, 21'h1, '0, sig);
    wait_idle(bc);
    chk("zero_busy", bc, 1);
    chk("zero_done_cycle", done_cyc(), 1);
    chk("zero_sig", signature, 19'h7FFFF);
    chk("zero_pass", pass, 1);
    run_start(0, 0, 21'h1, 19'h7FFFF, sig);
    wait_idle(bc);
    chk("zero_fail_pass", pass, 0);

    run_start(0, 2, 21'h0, '0, sig);
    wait_idle(bc);
    chk("seed0_last_vec", dut_x, 21'h2);
    chk("seed0_pass", pass, 1);

    ev[0] = 21'h12345; ev[1] = 21'h0ABCD; ev[2] = 21'h1F00F;
    run_start(1, 3, '0, '0, sig);
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      if (k == 1) repeat (5) begin
        chk("stall_ready", ext_ready, 1);
        chk("stall_hold", dut_x, ev[0]);
        @(negedge clk);
      end
      ext_valid = 1'b1; ext_vec = ev[k];
      @(negedge clk);
      ext_valid = 1'b0;
    end
    wait_idle(bc);
    chk("ext_done_cycle", done_cyc(), 18);
    chk("ext_sig", signature, sig);
    chk("ext_pass", pass, 1);
    chk("ext_ready_idle", ext_ready, 0);

    run_start(0, 4, 21'h1ABCD, '0, sig_clean);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_dut_x", dut_x, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_sig", signature, 19'h7FFFF);
    vq.delete();
    sq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_still_idle", busy, 0);
    run_start(0, 4, 21'h1ABCD, '0, sig);
    wait_idle(bc);
    chk("rerun_sig", signature, sig_clean);
    chk("rerun_pass", pass, 1);

    run_start(0, 100, 21'h1ABCD, '0, sig);
    wait_idle(bc);
    chk("loop100_sig", signature, sig);
    chk("loop100_busy", bc, 401);
    chk("loop100_pass", pass, 1);
    run_start(0, 100, 21'h1ABCD, 19'h1, sig);
    wait_idle(bc);
    chk("loop100_sig2", signature, sig);
    chk("loop100_fail_pass", pass, 0);

    run_start(0, 4, 21'h5, '0, sig);
    @(posedge clk);
    #1 start = 1'b1; vec_count = 16'd1; seed = 21'h7; ext_mode = 1'b1; exp_sig = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(bc);
    chk("ign_done_cycle", done_cyc(), 17);
    chk("ign_sig", signature, sig);
    chk("ign_pass", pass, 1);
    ext_mode = 1'b0;

    repeat (2) @(negedge clk);
    chk("vq_empty", vq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
